nano6502_sim_driver: RTL and testbench
======================================

Name: nano6502_sim_driver

Overview:
- Parametrised stimulus and run-control block for the nano6502 simulation top.
- Serialises queued bytes onto the DUT's UART receive line through a depth-configurable FIFO and a configurable-frame UART transmitter.
- Carries a cycle watchdog that raises a sticky timeout flag after MAX_CYCLES. The top uses this flag to end the run instead of polling wall-clock time.
- Synthesisable, so it can also run on hardware as a loopback exerciser.

Parameters:
CLKS_PER_BIT, 16, clock cycles per UART bit (must be >= 2)
DATA_BITS, 8, data bits per frame (5..8); wr_data_i bits above DATA_BITS-1 are ignored
STOP_BITS, 1, stop bits per frame (1 or 2)
FIFO_DEPTH, 16, byte FIFO depth (power of two, >= 2)
MAX_CYCLES, 1000000, watchdog limit in clk_i cycles (>= 1)
CYC_W, 32, cycle counter width; must hold MAX_CYCLES

Ports:
clk_i  input  1  system clock
rst_i  input  1  asynchronous active-low reset
tx_en_i  input  1  1 = transmitter may start new frames
wr_valid_i  input  1  byte offered to FIFO
wr_data_i  input  8  byte to queue
wr_ready_o  output  1  FIFO can accept (not full)
uart_tx_o  output  1  serial line to DUT uart_rx_i, idle high
busy_o  output  1  frame in progress or FIFO non-empty
fifo_count_o  output  $clog2(FIFO_DEPTH)+1  bytes queued, excluding the frame being shifted
cycle_count_o  output  CYC_W  cycles since reset release, saturating at MAX_CYCLES
timeout_o  output  1  sticky; high once cycle_count_o == MAX_CYCLES

Behaviour:
- Reset (rst_i low, asynchronous): uart_tx_o=1, wr_ready_o=0 while held, busy_o=0, fifo_count_o=0, cycle_count_o=0, timeout_o=0, FSM=IDLE, FIFO emptied.
- Reset asserted mid-frame: the line returns high immediately and the partial frame is dropped. Release is synchronous to clk_i; wr_ready_o goes to 1 on the first clk_i edge after release.
- FIFO write: a byte is accepted on a clk_i edge when wr_valid_i && wr_ready_o. If full, writes are ignored with no overwrite and no error.
- FIFO simultaneous push and pop: when FIFO is full, push is blocked that cycle (wr_ready_o reflects pre-edge state); otherwise count is unchanged.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: if tx_en_i && FIFO non-empty, pop head into shift register and go to START on the same edge. uart_tx_o=1 in IDLE.
- START: uart_tx_o=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: LSB first, DATA_BITS bits, each held CLKS_PER_BIT cycles, then STOP.
- STOP: uart_tx_o=1 for STOP_BITS*CLKS_PER_BIT cycles, then IDLE.
- Back-to-back frames: IDLE lasts exactly one cycle between frames when data is available. Frame period is (1+DATA_BITS+STOP_BITS)*CLKS_PER_BIT+1 cycles.
- tx_en_i low: gates only the IDLE→START decision; a frame already in progress completes.
- Latency: byte written into an empty FIFO with tx_en_i=1 → start bit appears 2 cycles after the write edge (1 cycle FIFO visibility, 1 cycle pop/register).
- Bit timing: bit counter and baud counter are internal; the baud counter reloads at every state transition, so there is no drift.
- busy_o: registered, = (state != IDLE) || (fifo_count != 0).
- Watchdog: cycle_count_o increments every cycle after reset release and stops at MAX_CYCLES. timeout_o rises on the same edge the count reaches MAX_CYCLES, then stays high until reset. Watchdog is independent of the UART.

Test Plan:
1. Reset hold then release; no writes for 50 cycles -> uart_tx_o=1, busy_o=0, fifo_count_o=0, cycle_count_o=50 at cycle 50.
2. CLKS_PER_BIT=4, write 0xA5 with tx_en_i=1 -> start bit 2 cycles after write. Sampled line mid-bit reads 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop); frame 40 cycles; busy_o low after.
3. FIFO_DEPTH=4, tx_en_i=0, write 0x01..0x06 back-to-back -> wr_ready_o=0 after 4th, fifo_count_o=4. Then tx_en_i=1 -> exactly 0x01..0x04 emitted, 41 cycles apart start-to-start.
4. DATA_BITS=7, STOP_BITS=2, write 0xFF -> 7 ones after start bit; stop high for 8 cycles at CLKS_PER_BIT=4; bit 7 of the input ignored.
5. Assert rst_i low in the middle of the DATA state of a queued 3-byte burst -> uart_tx_o=1 immediately (asynchronously). After release: nothing transmitted, fifo_count_o=0.
6. MAX_CYCLES=100 -> timeout_o=0 at count 99, 1 at count 100. Count stays 100 and timeout_o stays high for 200 more cycles while UART traffic continues unaffected.

Source files
------------

// File: rtl/nano6502_sim_driver.sv
// Stimulus/run-control for the nano6502 sim top: byte FIFO feeding a UART
// transmitter, plus a saturating cycle watchdog with a sticky timeout flag.
`timescale 1ns/1ps
module nano6502_sim_driver #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16,
    parameter int MAX_CYCLES   = 1000000,
    parameter int CYC_W        = 32
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          tx_en_i,
    input  logic                          wr_valid_i,
    input  logic [7:0]                    wr_data_i,
    output logic                          wr_ready_o,
    output logic                          uart_tx_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic [CYC_W-1:0]              cycle_count_o,
    output logic                          timeout_o
);
    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int CNT_W     = PTR_W + 1;
    localparam int STOP_CLKS = STOP_BITS * CLKS_PER_BIT;
    localparam int BAUD_W    = $clog2(STOP_CLKS + 1);
    localparam int BIT_W     = $clog2(DATA_BITS);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]     r_count;
    logic                 r_wr_ready;
    state_t               r_state;
    logic [BAUD_W-1:0]    r_baud;
    logic [BIT_W-1:0]     r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_tx;
    logic                 r_busy;
    logic [CYC_W-1:0]     r_cyc;
    logic                 r_timeout;

    logic                 w_push, w_pop, w_stop_done, w_busy_next;
    logic [CNT_W-1:0]     w_count_next;

    assign w_push      = wr_valid_i && r_wr_ready;
    assign w_pop       = (r_state == IDLE) && tx_en_i && (r_count != '0);
    assign w_stop_done = (r_state == STOP) && (r_baud == BAUD_W'(STOP_CLKS - 1));

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop)
            w_count_next = r_count + 1'b1;
        else if (!w_push && w_pop)
            w_count_next = r_count - 1'b1;
    end

    // busy reflects the state/count that this edge will establish
    assign w_busy_next = w_pop || ((r_state != IDLE) && !w_stop_done) || (w_count_next != '0);

    always_ff @(posedge clk_i) begin
        if (w_push)
            r_mem[r_wr_ptr] <= wr_data_i[DATA_BITS-1:0];
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_wr_ready <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count    <= w_count_next;
            r_wr_ready <= (w_count_next != CNT_W'(FIFO_DEPTH));
        end
    end

    // Line is registered from the current state, so it trails the FSM by one cycle
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state   <= IDLE;
            r_baud    <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_busy <= w_busy_next;
            unique case (r_state)
                IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_shift <= r_mem[r_rd_ptr];
                        r_baud  <= '0;
                        r_state <= START;
                    end
                end
                START: begin
                    r_tx <= 1'b0;
                    if (r_baud == BAUD_W'(CLKS_PER_BIT - 1)) begin
                        r_baud    <= '0;
                        r_bit_cnt <= '0;
                        r_state   <= DATA;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                DATA: begin
                    r_tx <= r_shift[0];
                    if (r_baud == BAUD_W'(CLKS_PER_BIT - 1)) begin
                        r_baud  <= '0;
                        r_shift <= r_shift >> 1;
                        if (r_bit_cnt == BIT_W'(DATA_BITS - 1))
                            r_state <= STOP;
                        else
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                STOP: begin
                    r_tx <= 1'b1;
                    if (w_stop_done) begin
                        r_baud  <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cyc     <= '0;
            r_timeout <= 1'b0;
        end else if (r_cyc != CYC_W'(MAX_CYCLES)) begin
            r_cyc <= r_cyc + 1'b1;
            if (r_cyc == CYC_W'(MAX_CYCLES - 1))
                r_timeout <= 1'b1;
        end
    end

    assign wr_ready_o    = r_wr_ready;
    assign uart_tx_o     = r_tx;
    assign busy_o        = r_busy;
    assign fifo_count_o  = r_count;
    assign cycle_count_o = r_cyc;
    assign timeout_o     = r_timeout;
endmodule

// File: tb/tb_nano6502_sim_driver.sv
// Bench: two driver instances (8N1 and 7-data/2-stop) checked every cycle
// against a timeline model, plus directed frame decoding and literal checks.
`timescale 1ns/1ps
module tb_nano6502_sim_driver;
    localparam int C = 4;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] rst_n, tx_en, wr_valid;
    logic [7:0] wr_data [2];
    logic [1:0] wr_ready, uart, busy, tout;
    logic [2:0] fcnt [2];
    logic [31:0] cyc [2];

    nano6502_sim_driver #(.CLKS_PER_BIT(4), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4),
                          .MAX_CYCLES(100), .CYC_W(32)) u_a (
        .clk_i(clk), .rst_i(rst_n[0]), .tx_en_i(tx_en[0]), .wr_valid_i(wr_valid[0]),
        .wr_data_i(wr_data[0]), .wr_ready_o(wr_ready[0]), .uart_tx_o(uart[0]),
        .busy_o(busy[0]), .fifo_count_o(fcnt[0]), .cycle_count_o(cyc[0]), .timeout_o(tout[0]));

    nano6502_sim_driver #(.CLKS_PER_BIT(4), .DATA_BITS(7), .STOP_BITS(2), .FIFO_DEPTH(4),
                          .MAX_CYCLES(1000), .CYC_W(32)) u_b (
        .clk_i(clk), .rst_i(rst_n[1]), .tx_en_i(tx_en[1]), .wr_valid_i(wr_valid[1]),
        .wr_data_i(wr_data[1]), .wr_ready_o(wr_ready[1]), .uart_tx_o(uart[1]),
        .busy_o(busy[1]), .fifo_count_o(fcnt[1]), .cycle_count_o(cyc[1]), .timeout_o(tout[1]));

    int n_checks = 0;
    int n_err = 0;
    int cyc_now = 0;
    bit done_b = 0;

    function automatic int p_d(int k);   return (k == 0) ? 8 : 7;       endfunction
    function automatic int p_s(int k);   return (k == 0) ? 1 : 2;       endfunction
    function automatic int p_max(int k); return (k == 0) ? 100 : 1000;  endfunction
    function automatic int frame(int k); return (1 + p_d(k) + p_s(k)) * C; endfunction

    task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d] got %0h expected %0h at %0t", nm, k, act, exp, $time);
        end
    endtask

    // Model: a frame popped at model cycle tp drives the line for cycles tp+1..tp+FRAME
    logic [7:0] m_q0[$], m_q1[$];
    int         m_t [2];
    int         m_tpop [2];
    logic [7:0] m_byte [2];
    logic       m_rdy [2];

    function automatic int q_size(int k);
        return (k == 0) ? m_q0.size() : m_q1.size();
    endfunction

    function automatic bit m_idle(int k);
        return (m_tpop[k] < 0) || (m_t[k] - m_tpop[k] >= frame(k));
    endfunction

    function automatic logic m_line(int k);
        int n, b;
        if (m_tpop[k] < 0) return 1'b1;
        n = m_t[k] - m_tpop[k];
        if (n < 1 || n > frame(k)) return 1'b1;
        b = (n - 1) / C;
        if (b == 0) return 1'b0;
        if (b <= p_d(k)) return m_byte[k][b-1];
        return 1'b1;
    endfunction

    task automatic model_edge(int k);
        bit push, pop;
        logic [7:0] d;
        push = wr_valid[k] && m_rdy[k];
        pop  = m_idle(k) && tx_en[k] && (q_size(k) > 0);
        d    = wr_data[k] & 8'((1 << p_d(k)) - 1);
        m_t[k]++;
        if (pop) begin
            m_byte[k] = (k == 0) ? m_q0.pop_front() : m_q1.pop_front();
            m_tpop[k] = m_t[k];
        end
        if (push) begin
            if (k == 0) m_q0.push_back(d); else m_q1.push_back(d);
        end
        m_rdy[k] = (q_size(k) < DEPTH);
    endtask

    task automatic model_reset(int k);
        m_t[k] = 0;
        m_tpop[k] = -1;
        m_byte[k] = 8'h00;
        m_rdy[k] = 1'b0;
        if (k == 0) m_q0.delete(); else m_q1.delete();
    endtask

    always @(posedge clk) begin
        cyc_now++;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n[k]) model_reset(k);
            else model_edge(k);
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n[k]) begin
                chk("rst_uart", k, 32'(uart[k]), 32'd1);
                chk("rst_ready", k, 32'(wr_ready[k]), 32'd0);
                chk("rst_busy", k, 32'(busy[k]), 32'd0);
                chk("rst_fcnt", k, 32'(fcnt[k]), 32'd0);
                chk("rst_cyc", k, cyc[k], 32'd0);
                chk("rst_tout", k, 32'(tout[k]), 32'd0);
            end else begin
                chk("m_uart", k, 32'(uart[k]), 32'(m_line(k)));
                chk("m_ready", k, 32'(wr_ready[k]), 32'(m_rdy[k]));
                chk("m_busy", k, 32'(busy[k]), 32'(!m_idle(k) || q_size(k) != 0));
                chk("m_fcnt", k, 32'(fcnt[k]), 32'(q_size(k)));
                chk("m_cyc", k, cyc[k], 32'((m_t[k] < p_max(k)) ? m_t[k] : p_max(k)));
                chk("m_tout", k, 32'(tout[k]), 32'(m_t[k] >= p_max(k)));
            end
        end
    end

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wr(int k, logic [7:0] d);
        wr_data[k] = d;
        wr_valid[k] = 1'b1;
        step(1);
        wr_valid[k] = 1'b0;
    endtask

    // Finds the start bit, samples each bit mid-way and checks every stop cycle
    task automatic rx_frame(int k, output logic [7:0] d, output int s);
        bit found = 0;
        d = 8'h00;
        s = -1;
        for (int n = 0; n < 300 && !found; n++) begin
            step(1);
            if (uart[k] == 1'b0) found = 1;
        end
        chk("rx_start_seen", k, 32'(found), 32'd1);
        if (!found) return;
        s = cyc_now;
        step(2);
        chk("rx_start_mid", k, 32'(uart[k]), 32'd0);
        for (int i = 0; i < p_d(k); i++) begin
            step(4);
            d[i] = uart[k];
        end
        step(2);
        for (int j = 0; j < p_s(k) * C; j++) begin
            chk("rx_stop", k, 32'(uart[k]), 32'd1);
            step(1);
        end
    endtask

    task automatic expect_quiet(int k, int n);
        bit low = 0;
        for (int i = 0; i < n; i++) begin
            step(1);
            if (uart[k] == 1'b0) low = 1;
        end
        chk("line_quiet", k, 32'(low), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "bench time limit");
    end

    initial begin : inst_b
        logic [7:0] d;
        int s0, s1;
        rst_n[1] = 1'b1; tx_en[1] = 1'b0; wr_valid[1] = 1'b0; wr_data[1] = 8'h00;
        #1 rst_n[1] = 1'b0;
        step(3);
        rst_n[1] = 1'b1;
        step(1);
        tx_en[1] = 1'b1;
        wr(1, 8'hFF);
        wr(1, 8'h80);
        rx_frame(1, d, s0);
        chk("b_ff_as_7bit", 1, 32'(d), 32'h7F);
        rx_frame(1, d, s1);
        chk("b_bit7_ignored", 1, 32'(d), 32'h00);
        chk("b_period", 1, 32'(s1 - s0), 32'd41);
        step(5);
        chk("b_idle_busy", 1, 32'(busy[1]), 32'd0);
        chk("b_idle_line", 1, 32'(uart[1]), 32'd1);
        done_b = 1;
    end

    initial begin : inst_a
        logic [9:0] exp2;
        logic [7:0] d;
        int s, prev;
        bit seen, started;
        rst_n[0] = 1'b1; tx_en[0] = 1'b0; wr_valid[0] = 1'b0; wr_data[0] = 8'h00;
        #1 rst_n[0] = 1'b0;
        step(3);
        chk("t1_rst_ready", 0, 32'(wr_ready[0]), 32'd0);
        chk("t1_rst_line", 0, 32'(uart[0]), 32'd1);

        // Idle run after release
        rst_n[0] = 1'b1;
        step(50);
        chk("t1_line", 0, 32'(uart[0]), 32'd1);
        chk("t1_busy", 0, 32'(busy[0]), 32'd0);
        chk("t1_fcnt", 0, 32'(fcnt[0]), 32'd0);
        chk("t1_cyc50", 0, cyc[0], 32'd50);
        chk("t1_ready", 0, 32'(wr_ready[0]), 32'd1);

        // Single 0xA5 frame: start bit two cycles after the write edge
        tx_en[0] = 1'b1;
        wr(0, 8'hA5);
        chk("t2_fcnt_w", 0, 32'(fcnt[0]), 32'd1);
        chk("t2_line_w", 0, 32'(uart[0]), 32'd1);
        step(1);
        chk("t2_line_w1", 0, 32'(uart[0]), 32'd1);
        chk("t2_fcnt_w1", 0, 32'(fcnt[0]), 32'd0);
        chk("t2_busy_w1", 0, 32'(busy[0]), 32'd1);
        step(1);
        chk("t2_line_w2", 0, 32'(uart[0]), 32'd0);
        step(2);
        exp2 = {1'b1, 8'hA5, 1'b0};
        for (int i = 0; i < 10; i++) begin
            chk("t2_bit", i, 32'(uart[0]), 32'(exp2[i]));
            step(4);
        end
        chk("t2_busy_after", 0, 32'(busy[0]), 32'd0);
        chk("t2_line_after", 0, 32'(uart[0]), 32'd1);

        // Fill the FIFO with tx disabled, overflow writes dropped
        tx_en[0] = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            wr_data[0] = 8'(i);
            wr_valid[0] = 1'b1;
            step(1);
            if (i == 4) begin
                chk("t3_ready_full", 0, 32'(wr_ready[0]), 32'd0);
                chk("t3_fcnt_full", 0, 32'(fcnt[0]), 32'd4);
            end
        end
        wr_valid[0] = 1'b0;
        chk("t3_fcnt_hold", 0, 32'(fcnt[0]), 32'd4);
        chk("t3_line_hold", 0, 32'(uart[0]), 32'd1);
        tx_en[0] = 1'b1;
        prev = 0;
        for (int i = 1; i <= 4; i++) begin
            rx_frame(0, d, s);
            chk("t3_byte", i, 32'(d), 32'(i));
            if (i > 1) chk("t3_spacing", i, 32'(s - prev), 32'd41);
            prev = s;
        end
        expect_quiet(0, 60);
        chk("t3_fcnt_end", 0, 32'(fcnt[0]), 32'd0);
        chk("t3_busy_end", 0, 32'(busy[0]), 32'd0);

        // Reset in the middle of a 3-byte burst
        wr(0, 8'h11);
        wr(0, 8'h22);
        wr(0, 8'h33);
        started = 0;
        for (int n = 0; n < 50 && !started; n++) begin
            step(1);
            if (uart[0] == 1'b0) started = 1;
        end
        chk("t5_started", 0, 32'(started), 32'd1);
        step(12);
        rst_n[0] = 1'b0;
        #1;
        chk("t5_line_async", 0, 32'(uart[0]), 32'd1);
        chk("t5_fcnt_async", 0, 32'(fcnt[0]), 32'd0);
        chk("t5_busy_async", 0, 32'(busy[0]), 32'd0);
        @(posedge clk);
        #2;
        step(2);
        rst_n[0] = 1'b1;
        expect_quiet(0, 80);
        chk("t5_fcnt_after", 0, 32'(fcnt[0]), 32'd0);
        chk("t5_busy_after", 0, 32'(busy[0]), 32'd0);

        // Watchdog saturation while traffic runs across the limit
        tx_en[0] = 1'b0;
        rst_n[0] = 1'b0;
        step(2);
        rst_n[0] = 1'b1;
        step(1);
        wr(0, 8'h5A);
        wr(0, 8'hC3);
        wr(0, 8'h0F);
        tx_en[0] = 1'b1;
        seen = 0;
        fork
            begin
                logic [7:0] dd;
                int ss;
                rx_frame(0, dd, ss);
                chk("t6_byte0", 0, 32'(dd), 32'h5A);
                rx_frame(0, dd, ss);
                chk("t6_byte1", 0, 32'(dd), 32'hC3);
                rx_frame(0, dd, ss);
                chk("t6_byte2", 0, 32'(dd), 32'h0F);
            end
            begin
                for (int n = 0; n < 400 && !seen; n++) begin
                    @(negedge clk);
                    if (cyc[0] == 32'd99) begin
                        seen = 1;
                        chk("t6_tout_at99", 0, 32'(tout[0]), 32'd0);
                        @(negedge clk);
                        chk("t6_cyc100", 0, cyc[0], 32'd100);
                        chk("t6_tout_at100", 0, 32'(tout[0]), 32'd1);
                    end
                end
                chk("t6_reached99", 0, 32'(seen), 32'd1);
            end
        join
        step(180);
        chk("t6_cyc_sat", 0, cyc[0], 32'd100);
        chk("t6_tout_sticky", 0, 32'(tout[0]), 32'd1);
        chk("t6_busy_end", 0, 32'(busy[0]), 32'd0);

        for (int n = 0; n < 2000 && !done_b; n++) step(1);
        chk("inst_b_done", 1, 32'(done_b), 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
